// File: rtl/exec_pkg.sv
// Shared definitions for the execution pipes: default widths, ALU opcodes,
// flag bit positions and the payload packing order.
package exec_pkg;

    localparam int DATA_W     = 8;
    localparam int DEF_ROB_W  = 5;
    localparam int DEF_PREG_W = 5;
    localparam int DEF_ARCH_W = 8;
    localparam int DEF_OP_W   = 4;
    localparam int DEF_IMM_W  = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_ADDI  = 4'd5,
        OP_ADC   = 4'd6,
        OP_PASSB = 4'd7
    } alu_op_e;

    // Payload is packed MSB-first as {rob, dest, flag, result, flags, arch}.
    function automatic int payload_width(input int rob_w, input int preg_w, input int arch_w);
        return rob_w + 2 * preg_w + 2 * DATA_W + arch_w;
    endfunction

endpackage

// File: rtl/arith_exec_pipe_if.sv
// Issue-side and completion-side handshake bundle of the arithmetic pipe.
interface arith_exec_pipe_if
    import exec_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int PREG_W = DEF_PREG_W,
    parameter int ARCH_W = DEF_ARCH_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int IMM_W  = DEF_IMM_W
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     opcode;
    logic [IMM_W-1:0]    immediate;
    logic [DATA_W-1:0]   op_a_val;
    logic [DATA_W-1:0]   op_b_val;
    logic [DATA_W-1:0]   flags_val;
    logic [ROB_W-1:0]    rob_entry;
    logic [PREG_W-1:0]   dest_reg;
    logic [PREG_W-1:0]   flag_reg;
    logic [ARCH_W-1:0]   arch_dest_regs;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [ROB_W-1:0]    rob_entry_out;
    logic [PREG_W-1:0]   dest_reg_out;
    logic [PREG_W-1:0]   flag_reg_out;
    logic [DATA_W-1:0]   result_val;
    logic [DATA_W-1:0]   result_flags;
    logic [ARCH_W-1:0]   arch_dest_regs_out;
    logic [OCC_W-1:0]    occupancy;

    modport master (
        output in_valid, opcode, immediate, op_a_val, op_b_val, flags_val,
               rob_entry, dest_reg, flag_reg, arch_dest_regs, flush, out_ready,
        input  in_ready, out_valid, rob_entry_out, dest_reg_out, flag_reg_out,
               result_val, result_flags, arch_dest_regs_out, occupancy
    );

    modport slave (
        input  in_valid, opcode, immediate, op_a_val, op_b_val, flags_val,
               rob_entry, dest_reg, flag_reg, arch_dest_regs, flush, out_ready,
        output in_ready, out_valid, rob_entry_out, dest_reg_out, flag_reg_out,
               result_val, result_flags, arch_dest_regs_out, occupancy
    );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU; unknown opcodes pass operand A and leave flags untouched.
module alu
    import exec_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int IMM_W = DEF_IMM_W
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] f_in,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] f_out
);
    alu_op_e           w_op;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W:0]   w_sum;
    logic              w_v;
    logic              w_keep;

    assign w_op  = alu_op_e'(4'(opcode));
    assign w_imm = DATA_W'(imm);

    // Result, carry/borrow (w_sum MSB) and signed overflow for each opcode.
    always_comb begin
        w_sum  = '0;
        w_v    = 1'b0;
        w_keep = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_sum = {1'b0, a} + {1'b0, b};
                w_v   = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                w_sum = {1'b0, a} - {1'b0, b};
                w_v   = (a[DATA_W-1] != b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:   w_sum = {1'b0, a & b};
            OP_OR:    w_sum = {1'b0, a | b};
            OP_XOR:   w_sum = {1'b0, a ^ b};
            OP_ADDI: begin
                w_sum = {1'b0, a} + {1'b0, w_imm};
                w_v   = (a[DATA_W-1] == w_imm[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_ADC: begin
                w_sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, f_in[FLAG_C]};
                w_v   = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_PASSB: w_sum = {1'b0, b};
            default: begin
                w_sum  = {1'b0, a};
                w_keep = 1'b1;
            end
        endcase
    end

    // Flag byte: low nibble rewritten, high nibble always passes through.
    always_comb begin
        q     = w_sum[DATA_W-1:0];
        f_out = f_in;
        if (!w_keep) begin
            f_out[FLAG_Z] = (w_sum[DATA_W-1:0] == {DATA_W{1'b0}});
            f_out[FLAG_C] = w_sum[DATA_W];
            f_out[FLAG_N] = w_sum[DATA_W-1];
            f_out[FLAG_V] = w_v;
        end else begin
            f_out = f_in;
        end
    end

endmodule

// File: rtl/arith_exec_pipe_stage.sv
// One pipeline slot: valid bit plus payload with clear/load/hold control.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    // Valid bit: reset and clear dominate, otherwise follow upstream when loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
        end
    end

    // Payload only captures real ops so bubbles leave the previous contents intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (!i_clear && i_load && i_valid) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/arith_exec_pipe.sv
// ALU followed by a STAGES-deep elastic pipeline with flush and occupancy count,
// feeding the writeback/ROB completion bus.
module arith_exec_pipe
    import exec_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int PREG_W = DEF_PREG_W,
    parameter int ARCH_W = DEF_ARCH_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input logic              clk,
    input logic              rst,
    arith_exec_pipe_if.slave bus
);
    localparam int PAY_W = payload_width(ROB_W, PREG_W, ARCH_W);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [DATA_W-1:0] w_alu_q;
    logic [DATA_W-1:0] w_alu_f;
    logic [PAY_W-1:0]  w_pay_in;
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_adv;
    logic [PAY_W-1:0]  w_pay [STAGES];
    logic              w_accept;
    logic              w_retire;
    logic [OCC_W-1:0]  r_occ;

    alu #(.OP_W(OP_W), .IMM_W(IMM_W)) u_alu (
        .opcode (bus.opcode),
        .imm    (bus.immediate),
        .a      (bus.op_a_val),
        .b      (bus.op_b_val),
        .f_in   (bus.flags_val),
        .q      (w_alu_q),
        .f_out  (w_alu_f)
    );

    assign w_pay_in = {bus.rob_entry, bus.dest_reg, bus.flag_reg,
                       w_alu_q, w_alu_f, bus.arch_dest_regs};

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             w_up_valid;
        logic [PAY_W-1:0] w_up_pay;

        if (g == 0) begin : g_head
            assign w_up_valid = bus.in_valid;
            assign w_up_pay   = w_pay_in;
        end else begin : g_body
            assign w_up_valid = w_valid[g-1];
            assign w_up_pay   = w_pay[g-1];
        end

        // Slot g frees up if it or any slot below it is empty, or the output drains.
        assign w_adv[g] = bus.out_ready | ~(&w_valid[STAGES-1:g]);

        pipe_stage #(.W(PAY_W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_clear (bus.flush),
            .i_load  (w_adv[g]),
            .i_valid (w_up_valid),
            .i_data  (w_up_pay),
            .o_valid (w_valid[g]),
            .o_data  (w_pay[g])
        );
    end

    assign bus.in_ready  = w_adv[0] & ~bus.flush;
    assign bus.out_valid = w_valid[STAGES-1] & ~bus.flush;
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_retire      = bus.out_valid & bus.out_ready;

    assign {bus.rob_entry_out, bus.dest_reg_out, bus.flag_reg_out,
            bus.result_val, bus.result_flags, bus.arch_dest_regs_out} = w_pay[STAGES-1];

    // Occupancy tracks the valid bits: +1 per accept, -1 per retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else if (bus.flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(w_retire);
        end
    end

    assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_arith_exec_pipe.sv
// Scoreboard bench for arith_exec_pipe (STAGES=2 main instance, STAGES=4 bubble instance).
module tb_arith_exec_pipe;
    import exec_pkg::*;

    typedef struct {
        logic [4:0] rob;
        logic [4:0] dest;
        logic [4:0] flag;
        logic [7:0] res;
        logic [7:0] flg;
        logic [7:0] arch;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arith_exec_pipe_if #(.STAGES(2)) bus2 ();
    arith_exec_pipe_if #(.STAGES(4)) bus4 ();

    arith_exec_pipe #(.STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    arith_exec_pipe #(.STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   peak = 0;
    bit   last_acc;
    bit   lat_chk = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference ALU written with wide integer arithmetic; returns {result, flags}.
    function automatic logic [15:0] model_alu(input logic [3:0] op, input logic [3:0] imm,
                                              input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] f);
        int ua, ub, sa, sbv, r, sr;
        logic c, v;
        logic [7:0] q;
        ua = a; ub = b; sa = $signed(a); sbv = $signed(b);
        r = 0; sr = 0; c = 1'b0;
        case (op)
            4'd0: begin r = ua + ub; sr = sa + sbv; c = (r > 255); end
            4'd1: begin r = ua - ub; sr = sa - sbv; c = (ua < ub); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: begin r = ua + int'(imm); sr = sa + int'(imm); c = (r > 255); end
            4'd6: begin r = ua + ub + int'(f[1]); sr = sa + sbv + int'(f[1]); c = (r > 255); end
            4'd7: r = ub;
            default: return {a, f};
        endcase
        v = (sr > 127) || (sr < -128);
        q = r[7:0];
        return {q, f[7:4], v, q[7], c, (q == 8'd0)};
    endfunction

    task automatic push_exp();
        exp_t e;
        logic [15:0] m;
        m = model_alu(bus2.opcode, bus2.immediate, bus2.op_a_val, bus2.op_b_val, bus2.flags_val);
        e.rob = bus2.rob_entry; e.dest = bus2.dest_reg; e.flag = bus2.flag_reg;
        e.res = m[15:8]; e.flg = m[7:0]; e.arch = bus2.arch_dest_regs; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("spurious_out", 32'(bus2.out_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            check_val("rob", 32'(bus2.rob_entry_out), 32'(e.rob));
            check_val("dest", 32'(bus2.dest_reg_out), 32'(e.dest));
            check_val("flag_reg", 32'(bus2.flag_reg_out), 32'(e.flag));
            check_val("result", 32'(bus2.result_val), 32'(e.res));
            check_val("flags", 32'(bus2.result_flags), 32'(e.flg));
            check_val("arch", 32'(bus2.arch_dest_regs_out), 32'(e.arch));
            if (lat_chk) check_val("latency", 32'(cyc - e.cyc), 32'd2);
        end
    endtask

    // One clock: evaluate handshakes just after the drive point, then wait for the next negedge.
    task automatic step();
        if (rand_ready) bus2.out_ready = 1'($urandom_range(0, 1));
        #1;
        last_acc = 1'b0;
        if (!rst) begin
            check_val("occupancy", 32'(bus2.occupancy), 32'(sb.size()));
            if (int'(bus2.occupancy) > peak) peak = int'(bus2.occupancy);
            if (bus2.out_valid && bus2.out_ready) pop_cmp();
            if (bus2.in_valid && bus2.in_ready) begin
                push_exp();
                last_acc = 1'b1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [3:0] imm, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] f, input logic [4:0] rob);
        bus2.opcode = op; bus2.immediate = imm; bus2.op_a_val = a; bus2.op_b_val = b;
        bus2.flags_val = f; bus2.rob_entry = rob; bus2.dest_reg = rob ^ 5'h15;
        bus2.flag_reg = rob + 5'd1; bus2.arch_dest_regs = 8'd1 << rob[2:0];
        bus2.in_valid = 1'b1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] imm, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] f, input logic [4:0] rob);
        set_op(op, imm, a, b, f, rob);
        for (int k = 0; k < 20; k++) begin
            step();
            if (last_acc) break;
        end
        check_val("issue_accepted", 32'(last_acc), 32'd1);
        bus2.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus2.out_ready = 1'b1;
        while ((sb.size() != 0 || bus2.occupancy != 0) && k < 40) begin
            step();
            k++;
        end
        check_val("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic set_op4(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [4:0] rob);
        bus4.opcode = op; bus4.immediate = 4'd0; bus4.op_a_val = a; bus4.op_b_val = b;
        bus4.flags_val = 8'h00; bus4.rob_entry = rob; bus4.dest_reg = rob;
        bus4.flag_reg = rob; bus4.arch_dest_regs = 8'h80; bus4.in_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        rst = 1'b1;
        set_op(4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 5'd0);
        bus2.in_valid = 1'b0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;
        set_op4(4'd0, 8'h00, 8'h00, 5'd0);
        bus4.in_valid = 1'b0; bus4.flush = 1'b0; bus4.out_ready = 1'b0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(bus2.out_valid), 32'd0);
        check_val("rst_rob", 32'(bus2.rob_entry_out), 32'd0);
        check_val("rst_result", 32'(bus2.result_val), 32'd0);
        check_val("rst_flags", 32'(bus2.result_flags), 32'd0);
        check_val("rst_occ", 32'(bus2.occupancy), 32'd0);
        check_val("rst_in_ready", 32'(bus2.in_ready), 32'd1);

        // Back-to-back stream with exact latency.
        lat_chk = 1'b1;
        for (int i = 1; i <= 3; i++) issue(4'd0, 4'd0, 8'h10, 8'h05, 8'hA0, 5'(i));
        drain();
        lat_chk = 1'b0;
        check_val("peak_occ", 32'(peak), 32'd2);
        check_val("add_model", 32'(model_alu(4'd0, 4'd0, 8'h10, 8'h05, 8'h00) >> 8), 32'h15);

        // Backpressure: only two accepts fit, head payload held.
        bus2.out_ready = 1'b0;
        issue(4'd1, 4'd0, 8'h05, 8'h10, 8'h00, 5'd4);
        issue(4'd6, 4'd0, 8'hFF, 8'h01, 8'h02, 5'd5);
        set_op(4'd5, 4'd9, 8'h7F, 8'h00, 8'h00, 5'd6);
        #1;
        check_val("bp_in_ready", 32'(bus2.in_ready), 32'd0);
        step(); step();
        #1;
        check_val("bp_hold_valid", 32'(bus2.out_valid), 32'd1);
        check_val("bp_hold_rob", 32'(bus2.rob_entry_out), 32'(sb[0].rob));
        check_val("bp_hold_res", 32'(bus2.result_val), 32'(sb[0].res));
        bus2.out_ready = 1'b1;
        issue(4'd5, 4'd9, 8'h7F, 8'h00, 8'h00, 5'd6);
        issue(4'd9, 4'd0, 8'h33, 8'h44, 8'h5A, 5'd7);
        drain();

        // Flush with the pipe full and an op at the input.
        bus2.out_ready = 1'b0;
        issue(4'd2, 4'd0, 8'hF0, 8'h3C, 8'h00, 5'd10);
        issue(4'd3, 4'd0, 8'hF0, 8'h3C, 8'h00, 5'd11);
        set_op(4'd4, 4'd0, 8'hAA, 8'h55, 8'h00, 5'd9);
        bus2.flush = 1'b1;
        #1;
        check_val("flush_out_valid", 32'(bus2.out_valid), 32'd0);
        check_val("flush_in_ready", 32'(bus2.in_ready), 32'd0);
        step();
        bus2.flush = 1'b0; bus2.in_valid = 1'b0;
        sb.delete();
        #1;
        check_val("flush_occ", 32'(bus2.occupancy), 32'd0);
        bus2.out_ready = 1'b1;
        repeat (5) step();

        // Reset while stalled and full.
        bus2.out_ready = 1'b0;
        issue(4'd0, 4'd0, 8'h01, 8'h02, 8'h00, 5'd12);
        issue(4'd0, 4'd0, 8'h03, 8'h04, 8'h00, 5'd13);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        #1;
        check_val("mrst_out_valid", 32'(bus2.out_valid), 32'd0);
        check_val("mrst_rob", 32'(bus2.rob_entry_out), 32'd0);
        check_val("mrst_dest", 32'(bus2.dest_reg_out), 32'd0);
        check_val("mrst_result", 32'(bus2.result_val), 32'd0);
        check_val("mrst_arch", 32'(bus2.arch_dest_regs_out), 32'd0);
        check_val("mrst_occ", 32'(bus2.occupancy), 32'd0);
        bus2.out_ready = 1'b1;
        repeat (4) step();

        // Simultaneous accept and drain keeps occupancy at two.
        bus2.out_ready = 1'b0;
        issue(4'd0, 4'd0, 8'h80, 8'h80, 8'h00, 5'd14);
        issue(4'd1, 4'd0, 8'h80, 8'h01, 8'h00, 5'd15);
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(4'(i), 4'd3, 8'(8'h40 + 8'(i)), 8'h41, 8'h02, 5'(20 + i));
            #1;
            check_val("simul_occ", 32'(bus2.occupancy), 32'd2);
        end
        drain();

        // Random traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0)
                issue(4'($urandom_range(0, 9)), 4'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 5'($urandom));
            else
                step();
        end
        rand_ready = 1'b0;
        drain();

        // Bubble collapse on the four-stage instance with its output stalled.
        set_op4(4'd0, 8'h01, 8'h02, 5'd7);
        #1;
        check_val("b4_accept7", 32'(bus4.in_ready), 32'd1);
        step();
        bus4.in_valid = 1'b0;
        step(); step();
        set_op4(4'd1, 8'h05, 8'h10, 5'd8);
        #1;
        check_val("b4_accept8", 32'(bus4.in_ready), 32'd1);
        step();
        bus4.in_valid = 1'b0;
        repeat (4) step();
        #1;
        check_val("b4_occ", 32'(bus4.occupancy), 32'd2);
        check_val("b4_in_ready", 32'(bus4.in_ready), 32'd1);
        check_val("b4_head_valid", 32'(bus4.out_valid), 32'd1);
        check_val("b4_head_rob", 32'(bus4.rob_entry_out), 32'd7);
        bus4.out_ready = 1'b1;
        step();
        #1;
        m = model_alu(4'd1, 4'd0, 8'h05, 8'h10, 8'h00);
        check_val("b4_second_valid", 32'(bus4.out_valid), 32'd1);
        check_val("b4_second_rob", 32'(bus4.rob_entry_out), 32'd8);
        check_val("b4_second_res", 32'(bus4.result_val), 32'(m[15:8]));
        check_val("b4_second_flags", 32'(bus4.result_flags), 32'(m[7:0]));
        step();
        #1;
        check_val("b4_empty_valid", 32'(bus4.out_valid), 32'd0);
        check_val("b4_empty_occ", 32'(bus4.occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
